// File: rtl/dac_sample_fifo.sv
// Memory-mapped 12-bit sample FIFO with a programmable rate timer feeding the SPI DAC block.
// Optional low-water interrupt (irq port, CTRL bit2 IRQ_MASK) is built when DACFIFO_IRQ_EN is defined.
module dac_sample_fifo #(
  parameter int DEPTH   = 16,
  parameter int MIN_DIV = 40,
  parameter int THRESH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sample,
  output logic [11:0] out
`ifdef DACFIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0] RST_DIV = 16'd1000;
  localparam logic [15:0] MIN_P   = 16'(MIN_DIV);
  localparam logic [15:0] RST_CNT = ((RST_DIV < MIN_P) ? MIN_P : RST_DIV) - 16'd1;

  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic [15:0]   div, cnt;
  logic          en, underflow, overflow;
`ifdef DACFIFO_IRQ_EN
  logic          irq_mask;
`endif

  logic        acc, wr, push_req, flush, div_wr, ctrl_wr, stat_wr, clr_en;
  logic        tick, empty, full, pop, push_ok;
  logic [15:0] eff_m1;
  logic [8:0]  lvl9;
  logic [31:0] rd_val;
  logic        unused_bits;

  // One access per valid burst: the acknowledge cycle itself never executes.
  assign acc      = valid && !ready;
  assign wr       = |wstrb;
  assign push_req = acc && wr && (addr[3:2] == 2'd0);
  assign div_wr   = acc && wr && (addr[3:2] == 2'd1);
  assign ctrl_wr  = acc && wr && (addr[3:2] == 2'd2);
  assign stat_wr  = acc && wr && (addr[3:2] == 2'd3);
  assign flush    = ctrl_wr && wdata[1];
  assign clr_en   = ctrl_wr && !wdata[0];

  assign eff_m1  = ((div < MIN_P) ? MIN_P : div) - 16'd1;
  assign tick    = en && (cnt == 16'd0) && !clr_en;
  assign empty   = (level == LW'(0));
  assign full    = (level == LW'(DEPTH));
  // A flush on the tick cycle makes the tick see an empty FIFO; an empty FIFO never bypasses a push.
  assign pop     = tick && !empty && !flush;
  assign push_ok = push_req && (!full || pop);
  assign lvl9    = 9'(level);

  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:20], wdata[17:16]};

  // Register read mux.
  always_comb begin
    rd_val = 32'd0;
    case (addr[3:2])
      2'd0: rd_val = 32'd0;
      2'd1: rd_val = {16'd0, div};
`ifdef DACFIFO_IRQ_EN
      2'd2: rd_val = {29'd0, irq_mask, 1'b0, en};
`else
      2'd2: rd_val = {31'd0, en};
`endif
      2'd3: rd_val = {12'd0, overflow, underflow, full, empty, 7'd0, lvl9};
      default: rd_val = 32'd0;
    endcase
  end

  // Sample storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= wdata[11:0];
    end
  end

  // Bus, timer, FIFO pointers, flags and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready     <= 1'b0;
      rdata     <= 32'd0;
      div       <= RST_DIV;
      en        <= 1'b0;
      cnt       <= RST_CNT;
      wptr      <= AW'(0);
      rptr      <= AW'(0);
      level     <= LW'(0);
      underflow <= 1'b0;
      overflow  <= 1'b0;
      sample    <= 1'b0;
      out       <= 12'd0;
`ifdef DACFIFO_IRQ_EN
      irq_mask  <= 1'b0;
      irq       <= 1'b0;
`endif
    end else begin
      ready <= acc;
      rdata <= (acc && !wr) ? rd_val : 32'd0;

      if (div_wr) begin
        div <= wdata[15:0];
      end
      if (ctrl_wr) begin
        en <= wdata[0];
`ifdef DACFIFO_IRQ_EN
        irq_mask <= wdata[2];
`endif
      end

      // DIV changes are picked up only here, at reload.
      if (!en || (cnt == 16'd0)) begin
        cnt <= eff_m1;
      end else begin
        cnt <= cnt - 16'd1;
      end

      if (flush) begin
        wptr  <= AW'(0);
        rptr  <= AW'(0);
        level <= LW'(0);
      end else begin
        if (push_ok) begin
          wptr <= wptr + AW'(1);
        end
        if (pop) begin
          rptr <= rptr + AW'(1);
        end
        if (push_ok && !pop) begin
          level <= level + LW'(1);
        end else if (pop && !push_ok) begin
          level <= level - LW'(1);
        end
      end

      sample <= pop;
      if (pop) begin
        out <= mem[rptr];
      end

      if (tick && (empty || flush)) begin
        underflow <= 1'b1;
      end else if (stat_wr && wdata[18]) begin
        underflow <= 1'b0;
      end
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end else if (stat_wr && wdata[19]) begin
        overflow <= 1'b0;
      end

`ifdef DACFIFO_IRQ_EN
      irq <= en && !irq_mask && ((32'(level) <= 32'(THRESH)) || underflow);
`endif
    end
  end

endmodule

// File: tb/tb_dac_sample_fifo.sv
// Directed self-checking bench for dac_sample_fifo (DEPTH=16, MIN_DIV=40, THRESH=4).
// The low-water interrupt steps run only when DACFIFO_IRQ_EN is defined.
module tb_dac_sample_fifo;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        ready;
  logic [31:0] rdata;
  logic        sample;
  logic [11:0] dout;
`ifdef DACFIFO_IRQ_EN
  logic        irq;
`endif

  dac_sample_fifo #(.DEPTH(16), .MIN_DIV(40), .THRESH(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .valid  (valid),
    .ready  (ready),
    .addr   (addr),
    .wstrb  (wstrb),
    .wdata  (wdata),
    .rdata  (rdata),
    .sample (sample),
    .out    (dout)
`ifdef DACFIFO_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          s_cyc[$];
  logic [11:0] s_val[$];
  always @(negedge clk) begin
    if (resetn && sample) begin
      s_cyc.push_back(cyc);
      s_val.push_back(dout);
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic bus(input logic [1:0] r, input logic [31:0] d, input logic w, output logic [31:0] v);
    int k;
    @(negedge clk);
    addr  = {28'd0, r, 2'b00};
    wdata = d;
    wstrb = w ? 4'hF : 4'h0;
    valid = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!ready && k < 8);
    check("bus_ready", {31'd0, ready}, 32'd1);
    v = rdata;
    valid = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] dummy;
    bus(r, d, 1'b1, dummy);
  endtask

  task automatic rd(input string tag, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] v;
    bus(r, 32'd0, 1'b0, v);
    check(tag, v, exp);
  endtask

  task automatic wait_n(input int n, input int budget);
    int k;
    k = 0;
    while (s_cyc.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("sample_count", s_cyc.size(), n);
  endtask

  initial begin
    int c_en;
    int seen;
    int k;

    // Reset values
    #12;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_sample", {31'd0, sample}, 32'd0);
    check("rst_out", {20'd0, dout}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    rd("rst_data", 2'd0, 32'd0);
    rd("rst_div", 2'd1, 32'd1000);
    rd("rst_ctrl", 2'd2, 32'd0);
    rd("rst_status", 2'd3, 32'h0001_0000);

    // Three samples at DIV=50, then an underflow tick
    wr(2'd0, 32'h123);
    wr(2'd0, 32'h456);
    wr(2'd0, 32'h789);
    wr(2'd1, 32'd50);
    s_cyc.delete();
    s_val.delete();
    wr(2'd2, 32'd1);
    c_en = cyc;
    wait_n(3, 200);
    check("t1_first", s_cyc[0], c_en + 50);
    check("t1_second", s_cyc[1], c_en + 100);
    check("t1_third", s_cyc[2], c_en + 150);
    check("t1_val0", {20'd0, s_val[0]}, 32'h123);
    check("t1_val1", {20'd0, s_val[1]}, 32'h456);
    check("t1_val2", {20'd0, s_val[2]}, 32'h789);
    while (cyc < c_en + 205) @(posedge clk);
    check("t1_no_fourth", s_cyc.size(), 3);
    check("t1_out_held", {20'd0, dout}, 32'h789);
    rd("t1_status", 2'd3, 32'h0005_0000);

    // MIN_DIV clamp
    wr(2'd2, 32'd0);
    wr(2'd3, 32'h000C_0000);
    wr(2'd1, 32'd5);
    rd("t2_div", 2'd1, 32'd5);
    wr(2'd0, 32'h111);
    wr(2'd0, 32'h222);
    s_cyc.delete();
    s_val.delete();
    wr(2'd2, 32'd1);
    c_en = cyc;
    wait_n(2, 150);
    check("t2_first", s_cyc[0], c_en + 40);
    check("t2_second", s_cyc[1], c_en + 80);
    check("t2_val1", {20'd0, s_val[1]}, 32'h222);

    // Overflow with EN=0
    wr(2'd2, 32'd0);
    wr(2'd2, 32'd2);
    wr(2'd3, 32'h000C_0000);
    rd("t3_clean", 2'd3, 32'h0001_0000);
    for (int i = 0; i < 17; i++) wr(2'd0, 32'hA00 + i);
    rd("t3_full", 2'd3, 32'h000A_0010);
    wr(2'd3, 32'h0008_0000);
    rd("t3_ovf_clr", 2'd3, 32'h0002_0010);

    // Push landing on the tick while full
    s_cyc.delete();
    s_val.delete();
    wr(2'd2, 32'd1);
    c_en = cyc;
    repeat (39) @(posedge clk);
    wr(2'd0, 32'hB00);
    rd("t4_status", 2'd3, 32'h0002_0010);
    check("t4_count", s_cyc.size(), 1);
    check("t4_when", s_cyc[0], c_en + 40);
    check("t4_val", {20'd0, s_val[0]}, 32'hA00);

    // Flush while running
    wr(2'd2, 32'd0);
    wr(2'd2, 32'd2);
    wr(2'd3, 32'h000C_0000);
    for (int i = 0; i < 10; i++) wr(2'd0, 32'hC00 + i);
    rd("t5_level10", 2'd3, 32'h0000_000A);
    s_cyc.delete();
    s_val.delete();
    wr(2'd2, 32'd1);
    c_en = cyc;
    wr(2'd2, 32'd3);
    rd("t5_flushed", 2'd3, 32'h0001_0000);
    rd("t5_ctrl", 2'd2, 32'd1);
    while (cyc < c_en + 45) @(posedge clk);
    rd("t5_underflow", 2'd3, 32'h0005_0000);
    check("t5_no_sample", s_cyc.size(), 0);

    // Asynchronous reset mid-period with LEVEL=5
    wr(2'd2, 32'd0);
    wr(2'd3, 32'h000C_0000);
    for (int i = 0; i < 5; i++) wr(2'd0, 32'hD00 + i);
    wr(2'd1, 32'd100);
    s_cyc.delete();
    s_val.delete();
    wr(2'd2, 32'd1);
    check("t6_out_before", {20'd0, dout}, 32'hA00);
    repeat (20) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("t6_ready", {31'd0, ready}, 32'd0);
    check("t6_rdata", rdata, 32'd0);
    check("t6_sample", {31'd0, sample}, 32'd0);
    check("t6_out", {20'd0, dout}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    rd("t6_div", 2'd1, 32'd1000);
    rd("t6_ctrl", 2'd2, 32'd0);
    rd("t6_status", 2'd3, 32'h0001_0000);
    check("t6_no_sample", s_cyc.size(), 0);

`ifdef DACFIFO_IRQ_EN
    // Low-water interrupt and mask
    wr(2'd1, 32'd40);
    for (int i = 0; i < 6; i++) wr(2'd0, 32'hE00 + i);
    check("t7_irq_off", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'd1);
    seen = 0;
    k = 0;
    while (seen < 2 && k < 200) begin
      @(negedge clk);
      if (sample) seen++;
      k++;
    end
    check("t7_pops", seen, 2);
    check("t7_irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("t7_irq_rise", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'd5);
    @(negedge clk);
    @(negedge clk);
    check("t7_irq_masked", {31'd0, irq}, 32'd0);
    rd("t7_ctrl", 2'd2, 32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dac_sample_fifo.md
# dac_sample_fifo

Memory-mapped sample buffer and rate timer that sits directly upstream of the SPI DAC block. Software pushes 12-bit samples into a FIFO over the bus. A programmable divider then pops one sample per period and presents it on `out`, with a one-cycle `sample` strobe. `sample`/`out` connect directly to the DAC block's `sample`/`in` inputs.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `MIN_DIV`, 40: minimum sample period in clocks; covers one full DAC transfer (35 clk) plus margin.
- `THRESH`, 4: low-water level for the IRQ (only with `DACFIFO_IRQ_EN`).

Ports:
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `valid`, in, 1: bus request.
- `ready`, out, 1: bus acknowledge.
- `addr`, in, 32: byte address; only `addr[3:2]` decoded.
- `wstrb`, in, 4: write strobes; any bit set = write, zero = read.
- `wdata`, in, 32: write data.
- `rdata`, out, 32: read data.
- `sample`, out, 1: one-cycle strobe, new value on `out`.
- `out`, out, 12: current sample, held between strobes.
- `irq`, out, 1: low-water interrupt; port exists only with `DACFIFO_IRQ_EN`.

## Operation
Register map (`addr[3:2]`):
- 0 DATA:
  - W: push `wdata[11:0]`.
  - R: 0.
- 1 DIV:
  - R/W `[15:0]`, period in clocks.
  - Effective period = max(DIV, `MIN_DIV`).
  - Reset value 1000.
- 2 CTRL:
  - bit0 EN.
  - bit1 FLUSH: write-only, self-clearing, reads 0.
  - Reset value 0.
- 3 STATUS:
  - `[8:0]` LEVEL.
  - bit16 EMPTY, bit17 FULL.
  - bit18 UNDERFLOW, sticky.
  - bit19 OVERFLOW, sticky.
  - Write 1 to bit18/bit19 clears that bit.

Bus access:
- Executed on cycles where `valid && !ready`.
- `ready <= valid && !ready` yields a one-clock acknowledge.
- Master holds `addr`/`wdata`/`wstrb` until `ready`, then drops `valid`.
- A held `valid` never causes a double access.

Timer:
- 16-bit down-counter reloaded with effective period − 1.
- Decrements only while EN=1.
- At 0 it fires a tick and reloads.
- Clearing EN reloads the counter and fires no tick.
- A DIV write takes effect at the next reload.

On a tick:
- FIFO non-empty: pop the head into `out` and assert `sample` for exactly one cycle.
- FIFO empty: no strobe, `out` unchanged, UNDERFLOW set.

FIFO boundary rules:
- Push while full with no pop in the same cycle: data dropped, OVERFLOW set.
- Push and pop in the same cycle when full: both succeed, LEVEL unchanged.
- Push and pop in the same cycle when empty: the push is stored and no pop occurs (UNDERFLOW set). Bypass to `out` is forbidden.
- FLUSH sets LEVEL to 0 and resets the pointers. A tick in the same cycle is treated as empty.
- Pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`. LEVEL is log2(`DEPTH`)+1 bits.

## Timing
- Reset values:
  - `ready`=0, `rdata`=0.
  - `sample`=0, `out`=0.
  - `irq`=0.
  - FIFO empty, counter = effective period − 1.
  - Sticky flags cleared.
- Asynchronous assertion of `resetn` mid-operation:
  - FIFO and flags cleared immediately.
  - `sample` drops within the same cycle.
  - No partial strobe on deassertion.
- Bus latency:
  - `ready` and `rdata` are valid 1 clk after `valid` rises.
  - A pushed word is poppable from the next clock.
- After EN is set, the first tick comes effective-period clocks later.
- Ticks are then spaced exactly effective-period clocks apart.
- `out` updates in the same registered cycle as `sample`=1.
- Strobe spacing is ≥ `MIN_DIV`, so every strobe lands while the DAC block is idle.

## Configuration
- `DACFIFO_IRQ_EN` defined:
  - `irq` port is present.
  - `irq` is registered: `irq` = EN && (LEVEL ≤ `THRESH` || UNDERFLOW).
  - CTRL bit2 IRQ_MASK, reset 0, forces `irq`=0 when set.
- `DACFIFO_IRQ_EN` undefined:
  - No `irq` port and no CTRL bit2; bit2 reads 0.
  - All other behaviour identical.

## Test plan
- Reset then read all four registers -> DATA 0, DIV 1000, CTRL 0, STATUS 0x0001_0000.
- Push 0x123, 0x456, 0x789; DIV=50; EN=1 -> three `sample` pulses 50 clk apart with `out`=0x123, 0x456, 0x789.
  - The fourth tick raises UNDERFLOW with no pulse; `out` stays 0x789.
- DIV=5 -> tick spacing 40 clk (`MIN_DIV` clamp).
- With EN=0, push 17 words at `DEPTH`=16 -> FULL=1, LEVEL=16, OVERFLOW=1.
  - Write 0x0008_0000 to STATUS -> OVERFLOW=0.
- Full FIFO with a push landing on the tick cycle -> push accepted, LEVEL stays 16, OVERFLOW stays 0.
- FLUSH while running with LEVEL=10 -> LEVEL 0, EMPTY=1; the next tick sets UNDERFLOW.
- Assert `resetn` low mid-period with LEVEL=5 -> outputs and registers take reset values immediately.
- With `DACFIFO_IRQ_EN`, `THRESH`=4: drain from 6 -> `irq` rises on the clock after LEVEL reaches 4; IRQ_MASK=1 -> `irq`=0.
